deadtime_gate_driver: RTL and testbench

Converts the switching variable produced by the hybrid control law into the two complementary gate commands of the resonant converter half-bridge. It sits directly downstream of the hybrid controller. It resynchronises and debounces the request by enforcing a minimum dwell time, and inserts a programmable dead time between the two legs. The applied leg state is returned as `o_sigma` and drives the controller's `i_sigma` feedback input.

---
 rtl/deadtime_gate_driver.sv | 139 +++++++++++++
 tb/tb_deadtime_gate_driver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/deadtime_gate_driver.sv
// Half-bridge gate driver: resynchronises the hybrid-control leg request,
// enforces a minimum on-time per leg and inserts dead time between legs.
module deadtime_gate_driver #(
  parameter int DEADTIME  = 16,
  parameter int MIN_DWELL = 50
) (
  input  logic i_CLK,
  input  logic i_RESET,
  input  logic i_sigma_req,
  input  logic i_enable,
  output logic o_gate_hi,
  output logic o_gate_lo,
  output logic o_sigma,
  output logic o_busy,
  output logic o_blocked
);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    DT_TO_HI = 3'd1,
    HI_ON    = 3'd2,
    DT_TO_LO = 3'd3,
    LO_ON    = 3'd4
  } state_t;

  localparam logic [15:0] DT_LAST   = 16'(DEADTIME - 1);
  localparam logic [15:0] DWELL_MAX = 16'(MIN_DWELL);

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_s1;
  logic        r_s2;
  logic [15:0] r_dtCnt;
  logic [15:0] r_dwell;
  logic        r_gateHi;
  logic        r_gateLo;
  logic        r_sigma;
  logic        r_busy;
  logic        r_blocked;
  logic        w_sigmaNext;
  logic        w_blockedNext;
  logic        w_dtDone;
  logic [15:0] w_dwellInc;
  logic        w_dwellDone;
  logic        w_legChange;

  // Two-flop synchronizer for the asynchronous leg request
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_sigma_req;
      r_s2 <= r_s1;
    end
  end

  // Dwell counts the current ON cycle too, so an ON state entered at edge e
  // may be left at edge e+MIN_DWELL at the earliest.
  assign w_dtDone    = (r_dtCnt == DT_LAST);
  assign w_dwellInc  = (r_dwell == DWELL_MAX) ? r_dwell : r_dwell + 16'd1;
  assign w_dwellDone = (w_dwellInc == DWELL_MAX);
  assign w_legChange = (r_s2 != r_sigma);

  always_comb begin
    w_stateNext   = r_state;
    w_sigmaNext   = r_sigma;
    w_blockedNext = 1'b0;
    if (!i_enable) begin
      w_stateNext = OFF;
    end else begin
      unique case (r_state)
        OFF: begin
          w_stateNext = r_s2 ? DT_TO_HI : DT_TO_LO;
          w_sigmaNext = r_s2;
        end
        DT_TO_HI: if (w_dtDone) w_stateNext = HI_ON;
        DT_TO_LO: if (w_dtDone) w_stateNext = LO_ON;
        HI_ON, LO_ON: begin
          if (w_legChange) begin
            if (w_dwellDone) begin
              w_stateNext = (r_state == HI_ON) ? DT_TO_LO : DT_TO_HI;
              w_sigmaNext = ~r_sigma;
            end else begin
              w_blockedNext = 1'b1;
            end
          end
        end
        default: w_stateNext = OFF;
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) r_state <= OFF;
    else          r_state <= w_stateNext;
  end

  // Counters restart whenever the state changes and stop at their limits
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      r_dtCnt <= 16'd0;
      r_dwell <= 16'd0;
    end else begin
      if ((r_state == DT_TO_HI || r_state == DT_TO_LO) && w_stateNext == r_state && !w_dtDone)
        r_dtCnt <= r_dtCnt + 16'd1;
      else
        r_dtCnt <= 16'd0;
      if ((r_state == HI_ON || r_state == LO_ON) && w_stateNext == r_state)
        r_dwell <= w_dwellInc;
      else
        r_dwell <= 16'd0;
    end
  end

  // Outputs are decoded from the next state so gates move on the same edge as the FSM
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      r_gateHi  <= 1'b0;
      r_gateLo  <= 1'b0;
      r_sigma   <= 1'b0;
      r_busy    <= 1'b0;
      r_blocked <= 1'b0;
    end else begin
      r_gateHi  <= (w_stateNext == HI_ON);
      r_gateLo  <= (w_stateNext == LO_ON);
      r_sigma   <= w_sigmaNext;
      r_busy    <= (w_stateNext == DT_TO_HI) || (w_stateNext == DT_TO_LO);
      r_blocked <= w_blockedNext;
    end
  end

  assign o_gate_hi = r_gateHi;
  assign o_gate_lo = r_gateLo;
  assign o_sigma   = r_sigma;
  assign o_busy    = r_busy;
  assign o_blocked = r_blocked;

endmodule

// File: tb/tb_deadtime_gate_driver.sv
// Randomized bench for deadtime_gate_driver against a timing-level model of
// the leg sequence (synchronizer delay, dead time, dwell, disable, reset).
module tb_deadtime_gate_driver;

  localparam int DT = 4;
  localparam int MD = 10;

  logic i_CLK = 1'b0;
  logic i_RESET;
  logic i_sigma_req;
  logic i_enable;
  logic o_gate_hi;
  logic o_gate_lo;
  logic o_sigma;
  logic o_busy;
  logic o_blocked;

  int totalChecks = 0;
  int badChecks   = 0;

  // Model: mode 0 = gates off, 1 = dead time, 2 = leg on
  bit mS1, mS2, mSig, mBlk;
  int mMode;
  int mElapsed;

  deadtime_gate_driver #(.DEADTIME(DT), .MIN_DWELL(MD)) dut (
    .i_CLK       (i_CLK),
    .i_RESET     (i_RESET),
    .i_sigma_req (i_sigma_req),
    .i_enable    (i_enable),
    .o_gate_hi   (o_gate_hi),
    .o_gate_lo   (o_gate_lo),
    .o_sigma     (o_sigma),
    .o_busy      (o_busy),
    .o_blocked   (o_blocked)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mS1 = 0; mS2 = 0; mSig = 0; mBlk = 0; mMode = 0; mElapsed = 0;
  endtask

  // One clock edge of the reference behaviour, using inputs present at the edge
  task automatic modelStep(input bit en, input bit rq);
    bit s2Old;
    s2Old = mS2;
    mS2 = mS1;
    mS1 = rq;
    mBlk = 0;
    if (!en) begin
      mMode = 0;
    end else if (mMode == 0) begin
      mMode = 1; mSig = s2Old; mElapsed = 0;
    end else if (mMode == 1) begin
      if (mElapsed + 1 == DT) begin mMode = 2; mElapsed = 0; end
      else mElapsed++;
    end else begin
      if (s2Old != mSig && mElapsed + 1 >= MD) begin
        mMode = 1; mSig = ~mSig; mElapsed = 0;
      end else begin
        if (s2Old != mSig) mBlk = 1;
        mElapsed++;
      end
    end
  endtask

  function automatic logic [4:0] modelVec();
    return {mMode == 2 && mSig, mMode == 2 && !mSig, mSig, mMode == 1, mBlk};
  endfunction

  function automatic logic [4:0] dutVec();
    return {o_gate_hi, o_gate_lo, o_sigma, o_busy, o_blocked};
  endfunction

  task automatic applyStimulus(input bit en, input bit rq);
    i_enable    = en;
    i_sigma_req = rq;
  endtask

  task automatic runCycle();
    bit en, rq;
    en = i_enable;
    rq = i_sigma_req;
    @(posedge i_CLK);
    modelStep(en, rq);
    #1;
    checkOutput("outputs", 32'(dutVec()), 32'(modelVec()));
    checkOutput("no_overlap", 32'(o_gate_hi & o_gate_lo), 32'd0);
  endtask

  initial begin
    int r;
    bit en, rq;
    i_RESET = 1'b0;
    applyStimulus(1'b0, 1'b1);
    modelReset();
    #2;
    checkOutput("reset_state", 32'(dutVec()), 32'd0);
    #10 i_RESET = 1'b1;

    for (int i = 0; i < 3; i++) runCycle();

    applyStimulus(1'b1, 1'b1);
    runCycle();
    checkOutput("enable_busy", 32'(o_busy), 32'd1);
    checkOutput("enable_sigma", 32'(o_sigma), 32'd1);
    checkOutput("enable_gates", 32'({o_gate_hi, o_gate_lo}), 32'd0);
    for (int i = 0; i < DT - 1; i++) begin
      runCycle();
      checkOutput("dt_busy", 32'(o_busy), 32'd1);
    end
    runCycle();
    checkOutput("hi_on", 32'({o_gate_hi, o_gate_lo, o_busy}), 32'b100);

    // Request drop after dwell: old gate falls 2 edges later, new rises DT after that
    for (int i = 0; i < MD; i++) runCycle();
    applyStimulus(1'b1, 1'b0);
    runCycle();
    runCycle();
    runCycle();
    checkOutput("hi_fall", 32'({o_gate_hi, o_sigma, o_busy}), 32'b001);
    for (int i = 0; i < DT - 1; i++) runCycle();
    checkOutput("lo_not_yet", 32'(o_gate_lo), 32'd0);
    runCycle();
    checkOutput("lo_rise", 32'(o_gate_lo), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      r  = int'($urandom_range(0, 99));
      en = i_enable;
      rq = i_sigma_req;
      if (r < 8) rq = ~rq;
      if (!en) en = ($urandom_range(0, 9) < 3);
      else if (r == 50) en = 1'b0;
      applyStimulus(en, rq);
      if (r == 60 || r == 61) begin
        i_sigma_req = ~rq;
        #3;
        i_sigma_req = rq;
      end
      if (c % 700 == 350) begin
        #1;
        i_RESET = 1'b0;
        #1;
        checkOutput("async_reset", 32'(dutVec()), 32'd0);
        modelReset();
        #2;
        i_RESET = 1'b1;
      end
      runCycle();
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
